// File: rtl/sd_image_loader.sv
// sd_image_loader: walks every block of one image region, fetching each
// 512-byte block from the SD block reader and unpacking it into 256
// sequential 16-bit writes to the frame-buffer write port.
module sd_image_loader #(
    parameter int BLOCKS_PER_IMG = 856,
    parameter int ADDR_W         = 18
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    input  logic [9:0]        img_id,
    output logic              busy,
    output logic              done,
    output logic [9:0]        sd_img_id,
    output logic [9:0]        sd_block_id,
    output logic              sd_r,
    input  logic              sd_done,
    input  logic [4095:0]     sd_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_ready
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOW,
        REQ,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [9:0] LAST_BLOCK = 10'(BLOCKS_PER_IMG - 1);

    state_t        state;
    logic [4095:0] blk_buf;
    logic [7:0]    word;
    logic [7:0]    word_next;

    // Index of the pixel that follows the one currently on mem_wdata.
    always_comb begin
        word_next = word + 8'd1;
    end

    // Control FSM with registered outputs; sd_block_id doubles as the block counter.
    // Word 0 is taken straight from sd_data on capture so the first write
    // appears one cycle after sd_done; later words come from the buffer.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            sd_img_id   <= '0;
            sd_block_id <= '0;
            sd_r        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            word        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sd_img_id   <= img_id;
                        sd_block_id <= '0;
                        busy        <= 1'b1;
                        state       <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!sd_done) begin
                        sd_r  <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (sd_done) begin
                        blk_buf   <= sd_data;
                        sd_r      <= 1'b0;
                        word      <= '0;
                        mem_we    <= 1'b1;
                        mem_wdata <= sd_data[15:0];
                        mem_addr  <= ADDR_W'({sd_block_id, 8'h00});
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_ready) begin
                        if (word == 8'hFF) begin
                            mem_we <= 1'b0;
                            if (sd_block_id == LAST_BLOCK) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= FINISH;
                            end else begin
                                sd_block_id <= sd_block_id + 10'd1;
                                state       <= WAIT_LOW;
                            end
                        end else begin
                            word      <= word_next;
                            mem_addr  <= mem_addr + ADDR_W'(1);
                            mem_wdata <= blk_buf[{word_next, 4'h0} +: 16];
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
